// File: rtl/router_pkg.sv
// Shared definitions for the router output-port reader: header layout,
// timeout default and framing state encoding.
package router_pkg;

  localparam int unsigned LEN_MSB  = 7;
  localparam int unsigned LEN_LSB  = 2;
  localparam int unsigned ADDR_MSB = 1;
  localparam int unsigned ADDR_LSB = 0;

  localparam int unsigned TIMEOUT_DEFAULT = 30;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2
  } state_t;

  function automatic logic [LEN_MSB-LEN_LSB:0] hdr_len(input logic [7:0] hdr);
    return hdr[LEN_MSB:LEN_LSB];
  endfunction

  function automatic logic [ADDR_MSB-ADDR_LSB:0] hdr_addr(input logic [7:0] hdr);
    return hdr[ADDR_MSB:ADDR_LSB];
  endfunction

endpackage

// File: rtl/router_timeout_cnt.sv
// Stall counter for the output handshake; expires after TIMEOUT stalled
// cycles and emits a registered one-cycle soft_reset pulse.
module router_timeout_cnt
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic stall,
  input  logic accept,
  output logic expire,
  output logic soft_reset
);

  localparam logic [7:0] TERM = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  assign expire = stall && (cnt == TERM);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else begin
      soft_reset <= expire;
      if (expire || accept) begin
        cnt <= '0;
      end else if (stall) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/router_pkt_reader.sv
// Read-side controller for one router output FIFO: frames header/payload/
// parity packets onto a valid/ready byte stream and checks parity.
module router_pkt_reader
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned DW      = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_re,
  output logic          soft_reset,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sop,
  output logic          out_eop,
  output logic [1:0]    pkt_addr,
  output logic          parity_err,
  output logic          busy
);

  localparam int unsigned LW = LEN_MSB - LEN_LSB + 1;

  state_t          state, state_nxt;
  logic            rd_pend;
  logic [LW-1:0]   rem;
  logic [DW-1:0]   acc;
  logic            accept;
  logic            stall;
  logic            flush;
  logic            eop_done;

  assign accept   = out_valid && out_ready;
  assign stall    = out_valid && !out_ready;
  assign eop_done = accept && out_eop;

  // Gated by resetn so that every output reads 0 while reset is held.
  assign fifo_re = resetn && !fifo_empty && !rd_pend && !soft_reset &&
                   (!out_valid || out_ready);

  router_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk        (clk),
    .resetn     (resetn),
    .stall      (stall),
    .accept     (accept),
    .expire     (flush),
    .soft_reset (soft_reset)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush || eop_done) begin
      state_nxt = IDLE;
    end else if (rd_pend) begin
      unique case (state)
        IDLE:    state_nxt = (hdr_len(fifo_dout) != '0) ? PAYLOAD : PARITY;
        PAYLOAD: if (rem == LW'(1)) state_nxt = PARITY;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_pend    <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      pkt_addr   <= '0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
      rem        <= '0;
      acc        <= '0;
    end else begin
      parity_err <= 1'b0;
      if (flush) begin
        // Timeout flush abandons the held byte and any pending read.
        rd_pend   <= 1'b0;
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop   <= 1'b0;
        busy      <= 1'b0;
        rem       <= '0;
        acc       <= '0;
      end else begin
        rd_pend <= fifo_re;
        if (rd_pend) begin
          out_data  <= fifo_dout;
          out_valid <= 1'b1;
          unique case (state)
            IDLE: begin
              rem      <= hdr_len(fifo_dout);
              pkt_addr <= hdr_addr(fifo_dout);
              out_sop  <= 1'b1;
              out_eop  <= 1'b0;
              busy     <= 1'b1;
              acc      <= fifo_dout;
            end
            PAYLOAD: begin
              rem     <= rem - LW'(1);
              acc     <= acc ^ fifo_dout;
              out_sop <= 1'b0;
              out_eop <= 1'b0;
            end
            default: begin
              out_sop <= 1'b0;
              out_eop <= 1'b1;
            end
          endcase
        end else if (accept) begin
          out_valid <= 1'b0;
          out_sop   <= 1'b0;
          out_eop   <= 1'b0;
        end
        if (eop_done) begin
          busy       <= 1'b0;
          acc        <= '0;
          parity_err <= (acc != out_data);
        end
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_reader.sv
// Bench for router_pkt_reader: queue-based FIFO and expected-byte scoreboard,
// directed packets plus a randomized handshake/empty run.
module tb_router_pkt_reader;

  localparam int TMO = 30;

  logic       clk = 1'b0;
  logic       resetn;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_re;
  logic       soft_reset;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sop;
  logic       out_eop;
  logic [1:0] pkt_addr;
  logic       parity_err;
  logic       busy;
  logic       hold_empty;

  router_pkt_reader #(.TIMEOUT(TMO), .DW(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_re    (fifo_re),
    .soft_reset (soft_reset),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .pkt_addr   (pkt_addr),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         sop;
    bit         eop;
    logic [1:0] addr;
    bit         err;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] q[$];
  logic [7:0] pl[64];
  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic fail(input string name);
    total_cnt++;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  task automatic push_raw(input logic [7:0] d, input bit sop, input bit eop,
                          input logic [1:0] addr, input bit err);
    exp_t e;
    e = '{d, sop, eop, addr, err};
    q.push_back(d);
    exp_q.push_back(e);
  endtask

  task automatic push_pkt(input logic [7:0] hdr, input bit bad);
    int unsigned len;
    logic [7:0]  x;
    len = hdr[7:2];
    x   = hdr;
    push_raw(hdr, 1'b1, 1'b0, hdr[1:0], 1'b0);
    for (int i = 0; i < int'(len); i++) begin
      push_raw(pl[i], 1'b0, 1'b0, hdr[1:0], 1'b0);
      x = x ^ pl[i];
    end
    push_raw(bad ? (x ^ 8'h01) : x, 1'b0, 1'b1, hdr[1:0], bad);
  endtask

  task automatic fill_payload();
    for (int i = 0; i < 64; i++) pl[i] = 8'($urandom);
  endtask

  // FIFO: read data appears the cycle after fifo_re; flushed by soft_reset.
  logic       re_s, sr_s;
  logic [7:0] pop_v;
  initial begin
    re_s = 1'b0;
    sr_s = 1'b0;
    forever begin
      @(negedge clk);
      re_s = fifo_re;
      sr_s = soft_reset;
      @(posedge clk);
      if (sr_s) q.delete();
      else if (re_s && q.size() > 0) begin
        pop_v = q.pop_front();
        #1 fifo_dout = pop_v;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2 fifo_empty = hold_empty || (q.size() == 0);
    end
  end

  // Scoreboard: accepted bytes in order, parity pulse after eop, timeout.
  int   stall_run = 0;
  bit   flush_due = 0, perr_due = 0, perr_exp = 0, busy_low_due = 0, prev_valid = 0;
  int   acc_cnt = 0, perr_seen = 0, sr_cnt = 0;
  int   sop_cyc = 0, eop_cyc = 0, rise_cyc = 0, sr_cyc = 0;
  exp_t e;

  always @(negedge clk) begin
    if (!resetn) begin
      chk("reset_outputs", {fifo_re, soft_reset, out_valid, out_sop, out_eop,
                            parity_err, busy, pkt_addr, out_data}, 0);
      stall_run    = 0;
      flush_due    = 0;
      perr_due     = 0;
      perr_exp     = 0;
      busy_low_due = 0;
      prev_valid   = 0;
    end else begin
      chk("re_when_empty", fifo_re & fifo_empty, 0);
      chk("soft_reset", soft_reset, flush_due);
      chk("parity_err", parity_err, perr_due ? perr_exp : 1'b0);
      if (busy_low_due) chk("busy_after_eop", busy, 0);
      if (flush_due) begin
        chk("flush_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
        chk("flush_re", fifo_re, 0);
        exp_q.delete();
      end
      if (soft_reset) begin
        sr_cnt++;
        sr_cyc = cyc;
      end
      if (parity_err) perr_seen++;
      if (out_valid && !prev_valid) rise_cyc = cyc;
      flush_due    = 0;
      perr_due     = 0;
      busy_low_due = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail("unexpected_byte");
        else begin
          e = exp_q.pop_front();
          chk("data", out_data, e.d);
          chk("sop", out_sop, e.sop);
          chk("eop", out_eop, e.eop);
          chk("addr", pkt_addr, e.addr);
          chk("busy_on_accept", busy, 1);
          acc_cnt++;
          if (e.sop) sop_cyc = cyc;
          if (e.eop) begin
            eop_cyc      = cyc;
            perr_due     = 1;
            perr_exp     = e.err;
            busy_low_due = 1;
          end
        end
        stall_run = 0;
      end else if (out_valid) begin
        stall_run++;
        if (stall_run >= TMO) begin
          flush_due = 1;
          stall_run = 0;
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (!(q.size() == 0 && exp_q.size() == 0 && !busy && !out_valid && !fifo_re)) begin
      @(posedge clk);
      #1;
      n++;
      if (n > budget) begin
        fail(name);
        return;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int a0, p0, s0, stall_left, sent;
    int unsigned len;
    logic [1:0]  addr;
    bit          found;

    resetn     = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    out_ready  = 1'b0;
    hold_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Nominal packet: 12 payload bytes, full rate
    fill_payload();
    out_ready = 1'b1;
    a0 = acc_cnt; p0 = perr_seen;
    push_pkt(8'h31, 1'b0);
    wait_idle(200, "t1_drain");
    chk("t1_bytes", acc_cnt - a0, 14);
    chk("t1_rate", eop_cyc - sop_cyc, 26);
    chk("t1_perr", perr_seen - p0, 0);
    chk("t1_addr", pkt_addr, 2'b01);

    // Same packet, corrupted parity
    a0 = acc_cnt; p0 = perr_seen;
    push_pkt(8'h31, 1'b1);
    wait_idle(200, "t2_drain");
    chk("t2_bytes", acc_cnt - a0, 14);
    chk("t2_perr", perr_seen - p0, 1);

    // Zero-length packet
    a0 = acc_cnt; p0 = perr_seen;
    push_raw(8'h02, 1'b1, 1'b0, 2'b10, 1'b0);
    push_raw(8'h02, 1'b0, 1'b1, 2'b10, 1'b0);
    wait_idle(100, "t3_drain");
    chk("t3_bytes", acc_cnt - a0, 2);
    chk("t3_perr", perr_seen - p0, 0);
    chk("t3_addr", pkt_addr, 2'b10);

    // Destination stalls: timeout flush, then a clean packet
    fill_payload();
    out_ready = 1'b0;
    s0 = sr_cnt;
    push_pkt(8'h31, 1'b0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #1;
      if (sr_cnt != s0) found = 1;
    end
    if (!found) fail("t4_no_soft_reset");
    chk("t4_delay", sr_cyc - rise_cyc, 30);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_pulses", sr_cnt - s0, 1);
    out_ready = 1'b1;
    fill_payload();
    a0 = acc_cnt;
    push_pkt(8'h1D, 1'b0);
    wait_idle(200, "t4_drain");
    chk("t4_bytes", acc_cnt - a0, 9);
    chk("t4_addr", pkt_addr, 2'b01);

    // Asynchronous reset mid-payload
    fill_payload();
    a0 = acc_cnt;
    push_pkt(8'hC1, 1'b0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt - a0 >= 5) found = 1;
    end
    if (!found) fail("t5_no_progress");
    @(posedge clk);
    #3 resetn = 1'b0;
    q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    #1 chk("async_reset", {fifo_re, soft_reset, out_valid, out_sop, out_eop,
                           parity_err, busy, pkt_addr, out_data}, 0);
    #9 resetn = 1'b1;
    @(posedge clk);
    #1;
    fill_payload();
    a0 = acc_cnt;
    push_pkt(8'h0A, 1'b0);
    wait_idle(200, "t5_drain");
    chk("t5_bytes", acc_cnt - a0, 4);
    chk("t5_addr", pkt_addr, 2'b10);

    // Random lengths, handshake and FIFO-empty gaps, occasional long stall
    sent = 0;
    stall_left = 0;
    for (int c = 0; c < 20000 && sent < 40; c++) begin
      @(posedge clk);
      #1;
      if (q.size() < 30) begin
        len  = ($urandom_range(0, 9) == 0) ? $urandom_range(21, 63) : $urandom_range(0, 20);
        addr = 2'($urandom);
        fill_payload();
        push_pkt({len[5:0], addr}, $urandom_range(0, 3) == 0);
        sent++;
      end
      if (c % 600 == 300) stall_left = 40;
      if (stall_left > 0) begin
        out_ready  = 1'b0;
        hold_empty = 1'b0;
        stall_left--;
      end else begin
        out_ready  = ($urandom_range(0, 99) < 60);
        hold_empty = ($urandom_range(0, 99) < 25);
      end
    end
    out_ready  = 1'b1;
    hold_empty = 1'b0;
    wait_idle(5000, "t6_drain");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
